csi_raw10_unpacker: RTL and testbench

CSI_RAW10_UNPACKER -- requirements
Module: csi_raw10_unpacker

---
 rtl/csi_raw10_unpacker_if.sv | 34 +++
 rtl/csi_raw10_unpacker.sv | 225 ++++++++++++++++++++++
 tb/tb_csi_raw10_unpacker.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csi_raw10_unpacker_if.sv
// csi_raw10_unpacker_if
// Bundles the byte-stream side and the pixel side of the RAW10 unpacker.
//   Receiver -> unpacker : image_data, image_data_enable, word_count,
//                          frame_start_strobe, frame_end_strobe, line_start_strobe
//   Unpacker -> consumer : pixel_group, pixel_group_valid, sof, eol,
//                          line_number, length_error
// master : the packet receiver / test driver side
// slave  : the unpacker itself
interface csi_raw10_unpacker_if;
  logic [31:0] image_data;
  logic        image_data_enable;
  logic [15:0] word_count;
  logic        frame_start_strobe;
  logic        frame_end_strobe;
  logic        line_start_strobe;
  logic [39:0] pixel_group;
  logic        pixel_group_valid;
  logic        sof;
  logic        eol;
  logic [15:0] line_number;
  logic        length_error;

  modport master (
    output image_data, image_data_enable, word_count,
           frame_start_strobe, frame_end_strobe, line_start_strobe,
    input  pixel_group, pixel_group_valid, sof, eol, line_number, length_error
  );

  modport slave (
    input  image_data, image_data_enable, word_count,
           frame_start_strobe, frame_end_strobe, line_start_strobe,
    output pixel_group, pixel_group_valid, sof, eol, line_number, length_error
  );
endinterface

// File: rtl/csi_raw10_unpacker.sv
// csi_raw10_unpacker
// Turns the CSI-2 long-packet byte stream of a RAW10 line into groups of four
// 10-bit pixels. Five wire bytes B0..B4 carry the upper 8 bits of P0..P3 in
// B0..B3 and the two LSBs of every pixel packed into B4.
//
// Ports:
//   clock_p : byte clock, everything on the rising edge
//   reset   : synchronous active-high reset
//   bus     : csi_raw10_unpacker_if.slave
//             in : image_data (byte 0 at [7:0]), image_data_enable,
//                  word_count, frame_start/frame_end/line_start strobes
//             out: pixel_group {P3,P2,P1,P0}, pixel_group_valid, sof, eol,
//                  line_number, length_error (sticky until next frame start)
//
// Parameter MAX_LINE_BYTES: largest word_count accepted without length_error.
//
// Build option CSI_RAW10_LINE_NUMBER_EN: when defined, a line counter drives
// line_number; otherwise line_number is tied to zero and no counter exists.
module csi_raw10_unpacker #(
  parameter logic [15:0] MAX_LINE_BYTES = 16'd6400
) (
  input logic                 clock_p,
  input logic                 reset,
  csi_raw10_unpacker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    LINE  = 2'd2
  } state_t;

  state_t      state_q, state_next;
  logic [63:0] buf_q, buf_next;
  logic [2:0]  fill_q, fill_next;
  logic [15:0] taken_q, taken_next;
  logic        sof_pend_q, sof_pend_next;
  logic        len_err_q, len_err_next;
  logic [39:0] group_q, group_next;
  logic        valid_q, valid_next;
  logic        sof_q, sof_next;
  logic        eol_q, eol_next;

  logic [15:0] remaining;
  logic [2:0]  take;
  logic [31:0] masked;
  logic [63:0] comb;
  logic [3:0]  comb_fill;
  logic [15:0] bytes_next;
  logic [39:0] group_data;
  logic        eol_hit;
  logic        wc_bad;

  // How many payload bytes this enable cycle contributes; padding beyond
  // word_count is never appended.
  assign remaining = bus.word_count - taken_q;

  always_comb begin
    take = 3'd0;
    if (state_q == LINE && bus.image_data_enable && taken_q < bus.word_count) begin
      take = (remaining >= 16'd4) ? 3'd4 : remaining[2:0];
    end
  end

  always_comb begin
    masked = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < take) begin
        masked[8*i +: 8] = bus.image_data[8*i +: 8];
      end
    end
  end

  // Buffer bytes above fill are always zero, so appending is a shifted OR.
  // The stored fill never exceeds 4, so the combined view never exceeds 8.
  assign comb       = buf_q | ({32'd0, masked} << {fill_q, 3'b000});
  assign comb_fill  = {1'b0, fill_q} + {1'b0, take};
  assign bytes_next = taken_q + {13'd0, take};

  assign group_data = {comb[31:24], comb[39:38],
                       comb[23:16], comb[37:36],
                       comb[15:8],  comb[35:34],
                       comb[7:0],   comb[33:32]};

  // The group being removed ends at line byte (bytes_next - comb_fill + 5) - 1;
  // it is the end-of-line group when that is byte word_count-1.
  assign eol_hit = ((bytes_next - {12'd0, comb_fill} + 16'd5) == bus.word_count);

  assign wc_bad = (bus.word_count == 16'd0) ||
                  ((bus.word_count % 16'd5) != 16'd0) ||
                  (bus.word_count > MAX_LINE_BYTES);

  // Next-state and datapath: frame_end beats frame_start beats line_start.
  always_comb begin
    state_next    = state_q;
    buf_next      = buf_q;
    fill_next     = fill_q;
    taken_next    = taken_q;
    sof_pend_next = sof_pend_q;
    len_err_next  = len_err_q;
    group_next    = group_q;
    valid_next    = 1'b0;
    sof_next      = 1'b0;
    eol_next      = 1'b0;

    if (bus.frame_end_strobe) begin
      state_next = IDLE;
      buf_next   = 64'd0;
      fill_next  = 3'd0;
      taken_next = 16'd0;
    end else if (bus.frame_start_strobe) begin
      state_next    = FRAME;
      buf_next      = 64'd0;
      fill_next     = 3'd0;
      taken_next    = 16'd0;
      sof_pend_next = 1'b1;
      len_err_next  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end
        FRAME: begin
          if (bus.line_start_strobe) begin
            state_next = LINE;
            buf_next   = 64'd0;
            fill_next  = 3'd0;
            taken_next = 16'd0;
            if (wc_bad) begin
              len_err_next = 1'b1;
            end
          end
        end
        LINE: begin
          if (bus.line_start_strobe) begin
            // A new line header before this line finished: drop the partial line.
            state_next   = FRAME;
            buf_next     = 64'd0;
            fill_next    = 3'd0;
            taken_next   = 16'd0;
            len_err_next = 1'b1;
          end else begin
            taken_next = bytes_next;
            if (comb_fill >= 4'd5) begin
              group_next    = group_data;
              valid_next    = 1'b1;
              sof_next      = sof_pend_q;
              sof_pend_next = 1'b0;
              eol_next      = eol_hit;
              buf_next      = comb >> 40;
              fill_next     = 3'(comb_fill - 4'd5);
            end else begin
              buf_next  = comb;
              fill_next = comb_fill[2:0];
            end
            // Line complete: any bytes short of a whole group are discarded.
            if (bytes_next >= bus.word_count) begin
              state_next = FRAME;
              buf_next   = 64'd0;
              fill_next  = 3'd0;
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock_p) begin
    if (reset) begin
      state_q    <= IDLE;
      buf_q      <= 64'd0;
      fill_q     <= 3'd0;
      taken_q    <= 16'd0;
      sof_pend_q <= 1'b0;
      len_err_q  <= 1'b0;
      group_q    <= 40'd0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
    end else begin
      state_q    <= state_next;
      buf_q      <= buf_next;
      fill_q     <= fill_next;
      taken_q    <= taken_next;
      sof_pend_q <= sof_pend_next;
      len_err_q  <= len_err_next;
      group_q    <= group_next;
      valid_q    <= valid_next;
      sof_q      <= sof_next;
      eol_q      <= eol_next;
    end
  end

  assign bus.pixel_group       = group_q;
  assign bus.pixel_group_valid = valid_q;
  assign bus.sof               = sof_q;
  assign bus.eol               = eol_q;
  assign bus.length_error      = len_err_q;

`ifdef CSI_RAW10_LINE_NUMBER_EN
  logic [15:0] line_q;
  logic        line_end;

  // Every LINE->FRAME exit counts, whether the line completed or was cut short.
  assign line_end = (state_q == LINE) && !bus.frame_end_strobe && !bus.frame_start_strobe &&
                    (bus.line_start_strobe || (bytes_next >= bus.word_count));

  always_ff @(posedge clock_p) begin
    if (reset) begin
      line_q <= 16'd0;
    end else if (bus.frame_start_strobe && !bus.frame_end_strobe) begin
      line_q <= 16'd0;
    end else if (line_end) begin
      line_q <= line_q + 16'd1;
    end
  end

  assign bus.line_number = line_q;
`else
  assign bus.line_number = 16'd0;
`endif

endmodule

// File: tb/tb_csi_raw10_unpacker.sv
// tb_csi_raw10_unpacker
// Directed bench for csi_raw10_unpacker. Line payloads are built from a word
// table; the expected pixel groups (data, sof, eol, arrival cycle) are derived
// byte by byte from the RAW10 packing rule and queued when the words are
// driven, then popped when the DUT raises pixel_group_valid.
module tb_csi_raw10_unpacker;

`ifdef CSI_RAW10_LINE_NUMBER_EN
  localparam bit LN_EN = 1'b1;
`else
  localparam bit LN_EN = 1'b0;
`endif

  typedef struct {
    logic [39:0] grp;
    logic        sof;
    logic        eol;
    int          due;
  } exp_t;

  logic clock_p = 1'b0;
  logic reset   = 1'b1;
  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;
  int   lines   = 0;
  bit   sof_armed = 1'b0;
  exp_t sb[$];
  logic [31:0] words[16];

  csi_raw10_unpacker_if bus ();

  csi_raw10_unpacker dut (
    .clock_p (clock_p),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clock_p = ~clock_p;

  // Cycle index used to check the one-cycle output latency.
  always @(posedge clock_p) cyc <= cyc + 1;

  // RAW10 packing rule applied to five wire bytes (B0 at [7:0]).
  function automatic logic [39:0] unpack(input logic [39:0] b);
    logic [39:0] r;
    r = 40'd0;
    for (int n = 0; n < 4; n++) begin
      r[10*n +: 10] = {b[8*n +: 8], b[32 + 2*n +: 2]};
    end
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle of strobes; word_count is presented together with them.
  task automatic apply_stimulus(input bit fs, input bit fe, input bit ls, input int wc);
    @(negedge clock_p);
    bus.word_count         = 16'(wc);
    bus.frame_start_strobe = fs;
    bus.frame_end_strobe   = fe;
    bus.line_start_strobe  = ls;
    if (fs && !fe) sof_armed = 1'b1;
    @(negedge clock_p);
    bus.frame_start_strobe = 1'b0;
    bus.frame_end_strobe   = 1'b0;
    bus.line_start_strobe  = 1'b0;
  endtask

  // Drive nwords from the word table; when expect_out is set, queue every
  // complete group of the first wc bytes at the cycle its fifth byte arrives.
  task automatic send_line(input int wc, input int nwords, input bit b2b, input bit expect_out);
    logic [39:0] acc;
    int cnt;
    int idx;
    exp_t e;
    acc = 40'd0;
    cnt = 0;
    for (int j = 0; j < nwords; j++) begin
      @(negedge clock_p);
      bus.image_data        = words[j];
      bus.image_data_enable = 1'b1;
      for (int p = 0; p < 4; p++) begin
        idx = 4*j + p;
        if (idx < wc) begin
          acc[8*cnt +: 8] = words[j][8*p +: 8];
          cnt++;
          if (cnt == 5) begin
            if (expect_out) begin
              e.grp = unpack(acc);
              e.sof = sof_armed;
              e.eol = (idx == wc - 1);
              e.due = cyc + 1;
              sb.push_back(e);
              sof_armed = 1'b0;
            end
            cnt = 0;
          end
        end
      end
      if (!b2b) begin
        @(negedge clock_p);
        bus.image_data_enable = 1'b0;
      end
    end
    @(negedge clock_p);
    bus.image_data_enable = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clock_p);
      n++;
    end
    check_output("drain", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clock_p);
  endtask

  // Scoreboard consumer: every valid group must match the head of the queue.
  always @(negedge clock_p) begin
    exp_t e;
    if (bus.pixel_group_valid === 1'b1) begin
      check_output("group_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_output("group_data", 64'(bus.pixel_group), 64'(e.grp));
        check_output("group_sof", 64'(bus.sof), 64'(e.sof));
        check_output("group_eol", 64'(bus.eol), 64'(e.eol));
        check_output("group_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.image_data         = 32'd0;
    bus.image_data_enable  = 1'b0;
    bus.word_count         = 16'd0;
    bus.frame_start_strobe = 1'b0;
    bus.frame_end_strobe   = 1'b0;
    bus.line_start_strobe  = 1'b0;

    // Reset values
    repeat (3) @(negedge clock_p);
    check_output("rst_pixel_group", 64'(bus.pixel_group), 64'd0);
    check_output("rst_valid", 64'(bus.pixel_group_valid), 64'd0);
    check_output("rst_sof", 64'(bus.sof), 64'd0);
    check_output("rst_eol", 64'(bus.eol), 64'd0);
    check_output("rst_line_number", 64'(bus.line_number), 64'd0);
    check_output("rst_length_error", 64'(bus.length_error), 64'd0);
    reset = 1'b0;

    // Basic 10-byte line with padding in the last word
    $display("[TB] basic line");
    apply_stimulus(1, 0, 0, 0);
    lines = 0;
    words[0] = 32'h04030201;
    words[1] = 32'h08070605;
    words[2] = 32'h0000AA09;
    apply_stimulus(0, 0, 1, 10);
    send_line(10, 3, 0, 1);
    wait_drain();
    lines++;
    check_output("basic_line_number", 64'(bus.line_number), LN_EN ? 64'(lines) : 64'd0);
    check_output("basic_length_error", 64'(bus.length_error), 64'd0);

    // word_count not a multiple of 5
    $display("[TB] word_count 12");
    apply_stimulus(1, 0, 0, 0);
    lines = 0;
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    apply_stimulus(0, 0, 1, 12);
    send_line(12, 3, 0, 1);
    wait_drain();
    lines++;
    check_output("wc12_length_error", 64'(bus.length_error), 64'd1);
    check_output("wc12_line_number", 64'(bus.line_number), LN_EN ? 64'(lines) : 64'd0);
    apply_stimulus(1, 0, 0, 0);
    lines = 0;
    check_output("wc12_error_cleared", 64'(bus.length_error), 64'd0);
    check_output("wc12_line_cleared", 64'(bus.line_number), 64'd0);

    // Back-to-back 40-byte line
    $display("[TB] word_count 40 back-to-back");
    for (int i = 0; i < 10; i++) words[i] = $urandom;
    apply_stimulus(0, 0, 1, 40);
    send_line(40, 10, 1, 1);
    wait_drain();
    lines++;
    check_output("wc40_length_error", 64'(bus.length_error), 64'd0);
    check_output("wc40_line_number", 64'(bus.line_number), LN_EN ? 64'(lines) : 64'd0);

    // Reset with 3 bytes still buffered
    $display("[TB] reset mid-line");
    apply_stimulus(1, 0, 0, 0);
    lines = 0;
    words[0] = 32'h44332211;
    words[1] = 32'h88776655;
    apply_stimulus(0, 0, 1, 20);
    send_line(20, 2, 1, 1);
    reset = 1'b1;
    sof_armed = 1'b0;
    @(negedge clock_p);
    check_output("mid_rst_pixel_group", 64'(bus.pixel_group), 64'd0);
    check_output("mid_rst_valid", 64'(bus.pixel_group_valid), 64'd0);
    check_output("mid_rst_sof", 64'(bus.sof), 64'd0);
    check_output("mid_rst_eol", 64'(bus.eol), 64'd0);
    check_output("mid_rst_line_number", 64'(bus.line_number), 64'd0);
    check_output("mid_rst_length_error", 64'(bus.length_error), 64'd0);
    reset = 1'b0;
    send_line(20, 2, 1, 0);
    wait_drain();

    // frame_end and line_start together: frame_end wins, nothing starts
    $display("[TB] frame_end with line_start");
    apply_stimulus(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    apply_stimulus(0, 1, 1, 10);
    send_line(10, 3, 1, 0);
    apply_stimulus(0, 0, 1, 10);
    send_line(10, 3, 1, 0);
    wait_drain();
    check_output("fe_ls_length_error", 64'(bus.length_error), 64'd0);
    check_output("fe_ls_line_number", 64'(bus.line_number), 64'd0);

    // Second line_start inside a line aborts it
    $display("[TB] line_start abort");
    apply_stimulus(1, 0, 0, 0);
    lines = 0;
    apply_stimulus(0, 0, 1, 10);
    send_line(10, 1, 1, 1);
    apply_stimulus(0, 0, 1, 10);
    lines++;
    check_output("abort_length_error", 64'(bus.length_error), 64'd1);
    check_output("abort_line_number", 64'(bus.line_number), LN_EN ? 64'(lines) : 64'd0);
    send_line(10, 3, 1, 0);
    wait_drain();

    // Three 5-byte lines in one frame
    $display("[TB] three lines");
    apply_stimulus(1, 0, 0, 0);
    lines = 0;
    for (int l = 0; l < 3; l++) begin
      words[0] = $urandom;
      words[1] = $urandom;
      apply_stimulus(0, 0, 1, 5);
      send_line(5, 2, 0, 1);
      wait_drain();
      lines++;
      check_output("multi_line_number", 64'(bus.line_number), LN_EN ? 64'(lines) : 64'd0);
    end
    check_output("multi_length_error", 64'(bus.length_error), 64'd0);

    // word_count limits
    $display("[TB] word_count limits");
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(0, 0, 1, 6400);
    check_output("wc_max_ok", 64'(bus.length_error), 64'd0);
    apply_stimulus(0, 1, 0, 6400);
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(0, 0, 1, 6405);
    check_output("wc_over_max", 64'(bus.length_error), 64'd1);
    apply_stimulus(0, 1, 0, 6405);
    apply_stimulus(1, 0, 0, 0);
    check_output("wc_err_cleared", 64'(bus.length_error), 64'd0);
    apply_stimulus(0, 0, 1, 0);
    check_output("wc_zero", 64'(bus.length_error), 64'd1);
    apply_stimulus(1, 1, 0, 0);
    check_output("fe_beats_fs", 64'(bus.length_error), 64'd1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
